// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-stage resolver for IF-stage branch predictions.
// Holds an in-order queue of fetch-time predictions. It compares the head entry
// against the EX outcome and produces the flush/redirect pulse and the
// predictor training write.
// Optional feature macro: BRU_STATS_EN enables the saturating branch and
// mispredict counters. When it is undefined, both counter outputs are tied to 0.
// Ports:
//   clk, reset (async, active-low)
//   pred_valid/pred_pc/pred_taken/pred_target -> prediction push; pred_ready = not full
//   res_valid/res_taken/res_target            -> resolve the oldest queued branch
//   flush, redirect_pc                         -> registered squash pulse + restart PC
//   upd_valid, upd_index, upd_taken            -> registered training write
//   inflight, res_err                          -> occupancy, sticky empty-resolve error
//   branch_count, mispredict_count             -> statistics (feature-gated)
module branch_resolve_unit #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned INDEX_W = 5,
  parameter int unsigned XLEN    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pred_valid,
  input  logic [XLEN-1:0]            pred_pc,
  input  logic                       pred_taken,
  input  logic [XLEN-1:0]            pred_target,
  output logic                       pred_ready,
  input  logic                       res_valid,
  input  logic                       res_taken,
  input  logic [XLEN-1:0]            res_target,
  output logic                       flush,
  output logic [XLEN-1:0]            redirect_pc,
  output logic                       upd_valid,
  output logic [INDEX_W-1:0]         upd_index,
  output logic                       upd_taken,
  output logic [$clog2(DEPTH+1)-1:0] inflight,
  output logic                       res_err,
  output logic [15:0]                branch_count,
  output logic [15:0]                mispredict_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0]    pc_q     [DEPTH];
  logic [XLEN-1:0]    pc_d     [DEPTH];
  logic [XLEN-1:0]    target_q [DEPTH];
  logic [XLEN-1:0]    target_d [DEPTH];
  logic [DEPTH-1:0]   taken_q, taken_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic               flush_q, flush_d;
  logic [XLEN-1:0]    redirect_q, redirect_d;
  logic               upd_valid_q, upd_valid_d;
  logic [INDEX_W-1:0] upd_index_q, upd_index_d;
  logic               upd_taken_q, upd_taken_d;
  logic               res_err_q, res_err_d;

  logic [PW-1:0]      occ;
  logic               empty, full, res_fire, mispredict, push_ok;
  logic [XLEN-1:0]    head_pc, head_target;
  logic               head_taken;

  // Extra wrap bit makes the pointer difference the exact occupancy
  assign occ         = wr_ptr_q - rd_ptr_q;
  assign empty       = (occ == PW'(0));
  assign full        = (occ == PW'(DEPTH));
  assign pred_ready  = !full;
  assign inflight    = CW'(occ);

  assign head_pc     = pc_q[rd_ptr_q[AW-1:0]];
  assign head_target = target_q[rd_ptr_q[AW-1:0]];
  assign head_taken  = taken_q[rd_ptr_q[AW-1:0]];

  assign res_fire    = res_valid && !empty;
  assign mispredict  = (head_taken != res_taken) || (res_taken && (head_target != res_target));
  // Pushes during a mispredict resolve or the following flush cycle are wrong-path
  assign push_ok     = pred_valid && !full && !flush_q && !(res_fire && mispredict);

  // Next-state: queue pointers/entries, resolve outputs, sticky error
  always_comb begin
    pc_d        = pc_q;
    target_d    = target_q;
    taken_d     = taken_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    flush_d     = 1'b0;
    redirect_d  = redirect_q;
    upd_valid_d = 1'b0;
    upd_index_d = upd_index_q;
    upd_taken_d = upd_taken_q;
    res_err_d   = res_err_q;

    if (res_valid && empty) res_err_d = 1'b1;

    if (res_fire) begin
      upd_valid_d = 1'b1;
      upd_index_d = head_pc[INDEX_W-1:0];
      upd_taken_d = res_taken;
      if (mispredict) begin
        flush_d    = 1'b1;
        redirect_d = res_taken ? res_target : head_pc + XLEN'(4);
        rd_ptr_d   = wr_ptr_q;
      end else begin
        rd_ptr_d   = rd_ptr_q + PW'(1);
      end
    end

    if (push_ok) begin
      pc_d[wr_ptr_q[AW-1:0]]     = pred_pc;
      target_d[wr_ptr_q[AW-1:0]] = pred_target;
      taken_d[wr_ptr_q[AW-1:0]]  = pred_taken;
      wr_ptr_d                   = wr_ptr_q + PW'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]     <= '0;
        target_q[i] <= '0;
      end
      taken_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
      upd_valid_q <= 1'b0;
      upd_index_q <= '0;
      upd_taken_q <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      target_q    <= target_d;
      taken_q     <= taken_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      flush_q     <= flush_d;
      redirect_q  <= redirect_d;
      upd_valid_q <= upd_valid_d;
      upd_index_q <= upd_index_d;
      upd_taken_q <= upd_taken_d;
      res_err_q   <= res_err_d;
    end
  end

  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign upd_valid   = upd_valid_q;
  assign upd_index   = upd_index_q;
  assign upd_taken   = upd_taken_q;
  assign res_err     = res_err_q;

`ifdef BRU_STATS_EN
  logic [15:0] branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;

  // Saturating statistics counters
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (res_fire && (branch_cnt_q != 16'hFFFF)) branch_cnt_d = branch_cnt_q + 16'd1;
    if (res_fire && mispredict && (mispred_cnt_q != 16'hFFFF)) mispred_cnt_d = mispred_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispred_cnt_q;
`else
  assign branch_count     = 16'd0;
  assign mispredict_count = 16'd0;
`endif

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
EX-stage counterpart to the IF-stage branch predictor.
- Holds an in-order queue of predictions issued at fetch.
- Compares each prediction against the actual outcome when EX resolves the branch.
- Drives the pipeline flush, the redirect PC, and the training write back into the predictor's 2-bit counter table.
- Sits between the fetch-side predictor and the EX-stage branch comparator.

Parameters:
DEPTH, 4, number of in-flight predicted branches held (IF..EX); power of two, at least 2
INDEX_W, 5, predictor table index width; index = pc[INDEX_W-1:0]
XLEN, 32, PC/target width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
pred_valid  input  1  fetch pushes a prediction record this cycle
pred_pc  input  XLEN  PC of the predicted branch
pred_taken  input  1  predicted direction
pred_target  input  XLEN  predicted target (meaningful only if pred_taken)
pred_ready  output  1  queue can accept a record (not full)
res_valid  input  1  EX resolves the oldest queued branch this cycle
res_taken  input  1  actual direction
res_target  input  XLEN  actual taken target
flush  output  1  one-cycle pulse: squash IF/ID/EX younger instructions
redirect_pc  output  XLEN  fetch restart PC, valid while flush=1
upd_valid  output  1  one-cycle training write to predictor
upd_index  output  INDEX_W  table index to train
upd_taken  output  1  actual outcome for the training write
inflight  output  $clog2(DEPTH+1)  current queue occupancy
res_err  output  1  sticky: resolve arrived with empty queue
branch_count  output  16  resolved-branch counter (feature-gated)
mispredict_count  output  16  mispredict counter (feature-gated)

Behaviour:
- Reset (reset=0, asynchronous): queue empty, inflight=0, pred_ready=1. flush, upd_valid, res_err, counters = 0. redirect_pc, upd_index, upd_taken = 0.
- Queue: circular FIFO, DEPTH entries of {pc, taken, target}. Pointers carry one extra wrap bit. full when occupancy=DEPTH.
- pred_ready = !full, combinational from registered occupancy. A push with pred_ready=0 is dropped, queue unchanged.
- Resolution: on res_valid with non-empty queue, pop the head and compare.
- Mispredict condition: (head.taken != res_taken) OR (res_taken AND head.target != res_target).
- Latency: all outputs are registered, asserted the cycle after res_valid.
  - upd_valid=1 for every resolution.
  - upd_index = head.pc[INDEX_W-1:0].
  - upd_taken = res_taken.
- Mispredict response:
  - flush=1 for exactly one cycle.
  - redirect_pc = res_taken ? res_target : head.pc+4 (mod 2^XLEN).
  - The entire queue is cleared at the same edge (younger entries are wrong-path).
  - A push in the resolve cycle is discarded.
  - A push in the flush cycle is also discarded (fetch not yet redirected).
- Correct prediction: flush=0, redirect_pc holds its previous value, only the head is popped.
- Simultaneous push + correct resolve: both take effect, occupancy unchanged. Legal when full only if the push is not attempted (pred_ready=0).
- res_valid with empty queue: res_err set (sticky until reset). No upd_valid, no flush, state unchanged.
- res_valid during the flush cycle: honoured only if the queue is non-empty. After a mispredict the queue is empty, so res_err is set.
- Wrap-around: pointers wrap modulo DEPTH. Occupancy is always correct across wrap.
- Reset mid-operation: immediate clear, including any in-progress flush pulse.

Optional Feature:
BRU_STATS_EN
- Defined: branch_count increments on every accepted resolution; mispredict_count increments on every mispredict. Both are 16-bit and saturate at 16'hFFFF.
- Undefined: no counter registers exist; both outputs are tied to 0.

Test Plan:
- Push {pc=0x100, taken=0}, resolve res_taken=0 -> next cycle: upd_valid=1, upd_index=0x00, upd_taken=0, flush=0, inflight 1->0.
- Push {pc=0x104, taken=0}, {pc=0x108, taken=1, target=0x200}; resolve res_taken=1, res_target=0x300 -> flush=1 one cycle, redirect_pc=0x300, upd_index=0x04, upd_taken=1, inflight=0 (0x108 squashed).
- Push {pc=0x11C, taken=1, target=0x80}; resolve res_taken=0 -> flush=1, redirect_pc=0x120, upd_index=0x1C, upd_taken=0.
- Push 4 entries with no resolve -> pred_ready=0. A 5th push is dropped. Resolve 4 times with correct outcomes -> 4 upd_valid pulses in FIFO order, then inflight=0. Repeat for 3 rounds to exercise wrap.
- res_valid with empty queue -> res_err=1 and stays 1; flush=0, upd_valid=0. Assert reset=0 mid-stream with 3 entries -> inflight=0, res_err=0 immediately, without a clock edge.
- With BRU_STATS_EN defined: 10 resolutions, 3 mispredicts -> branch_count=10, mispredict_count=3. Without the macro: both read 0.
